mc_ctrl_fsm: RTL and testbench

Multi-cycle sequencing controller for the MIPS-subset core. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB using ready/request handshakes to instruction and data memory. It classifies the held instruction word, detects illegal encodings and memory timeouts, and keeps cycle and retired-instruction counters. It sits between the IR/opcode fields and the datapath enables; the existing combinational decode continues to drive aluOP/brOP/mux selects.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_instr_class.sv | 46 ++++
 rtl/mc_ctrl_fsm.sv | 179 +++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset sequencing controller.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_LINK    = 3'd5,
    CL_ILLEGAL = 3'd6
  } class_e;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_IMEM_TO = 2'd2;
  localparam logic [1:0] TRAP_DMEM_TO = 2'd3;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

endpackage

// File: rtl/mc_instr_class.sv
// Combinational instruction classifier: (opcode, funct, rt) -> sequencing class.
module mc_instr_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic [4:0] i_rt,
  output logic [2:0] o_class
);

  class_e cls;

  always_comb begin
    cls = CL_ILLEGAL;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
            cls = CL_ALU;
          FN_JR:   cls = CL_JUMP;
          default: cls = CL_ILLEGAL;
        endcase
      end
      OP_REGIMM: begin
        if (i_rt == RT_BLTZ || i_rt == RT_BGEZ)
          cls = CL_BRANCH;
        else if (i_rt == RT_BLTZAL || i_rt == RT_BGEZAL)
          cls = CL_LINK;
        else
          cls = CL_ILLEGAL;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:                  cls = CL_BRANCH;
      OP_J:                                              cls = CL_JUMP;
      OP_JAL:                                            cls = CL_LINK;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:                  cls = CL_ALU;
      OP_LW, OP_LB:                                      cls = CL_LOAD;
      OP_SW, OP_SB:                                      cls = CL_STORE;
      default:                                           cls = CL_ILLEGAL;
    endcase
  end

  assign o_class = cls;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-timeout and illegal-op traps.
// state | meaning: FETCH wait imem | DECODE classify IR | EXEC branch/jump resolve | MEM wait dmem | WB reg write | TRAP halted
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic [4:0]       i_rt,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  input  logic             i_br_taken,
  output logic [2:0]       o_state,
  output logic             o_imemReq,
  output logic             o_irWe,
  output logic             o_pcInc,
  output logic             o_pcWe,
  output logic             o_dmemReq,
  output logic             o_dmemWe,
  output logic             o_regWe,
  output logic             o_retire,
  output logic             o_trap,
  output logic [1:0]       o_trapCode,
  output logic [CNT_W-1:0] o_cycleCnt,
  output logic [CNT_W-1:0] o_instrCnt
);

  localparam bit              TO_EN     = (MEM_TIMEOUT > 0);
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  class_e           cls_q, cls_d, cls_dec;
  logic [2:0]       cls_raw;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
  logic             timeout;

  mc_instr_class u_class (
    .i_opcode (i_opcode),
    .i_funct  (i_funct),
    .i_rt     (i_rt),
    .o_class  (cls_raw)
  );

  assign cls_dec = class_e'(cls_raw);
  assign timeout = TO_EN && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wait_d  = wait_q;
    code_d  = code_q;
    case (state_q)
      ST_FETCH: begin
        if (i_imem_ready) begin
          state_d = ST_DECODE;
          wait_d  = '0;
        end else if (timeout) begin
          state_d = ST_TRAP;
          code_d  = TRAP_IMEM_TO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        cls_d = cls_dec;
        if (cls_dec == CL_ILLEGAL) begin
          state_d = ST_TRAP;
          code_d  = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wait_d = '0;
        case (cls_q)
          CL_ALU, CL_LINK:   state_d = ST_WB;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (i_dmem_ready) begin
          state_d = (cls_q == CL_STORE) ? ST_FETCH : ST_WB;
          wait_d  = '0;
        end else if (timeout) begin
          state_d = ST_TRAP;
          code_d  = TRAP_DMEM_TO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        wait_d  = '0;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: begin
        state_d = ST_FETCH;
        wait_d  = '0;
      end
    endcase
  end

  // Strobes are forced low while rst_n is asserted so a reset mid-instruction has no side effects.
  always_comb begin
    o_imemReq = 1'b0;
    o_irWe    = 1'b0;
    o_pcInc   = 1'b0;
    o_pcWe    = 1'b0;
    o_dmemReq = 1'b0;
    o_dmemWe  = 1'b0;
    o_regWe   = 1'b0;
    o_retire  = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          o_imemReq = 1'b1;
          o_irWe    = i_imem_ready;
          o_pcInc   = i_imem_ready;
        end
        ST_EXEC: begin
          if (cls_q == CL_BRANCH) begin
            o_pcWe   = i_br_taken;
            o_retire = 1'b1;
          end else if (cls_q == CL_JUMP) begin
            o_pcWe   = 1'b1;
            o_retire = 1'b1;
          end
        end
        ST_MEM: begin
          o_dmemReq = 1'b1;
          o_dmemWe  = (cls_q == CL_STORE);
          o_retire  = (cls_q == CL_STORE) && i_dmem_ready;
        end
        ST_WB: begin
          o_regWe  = 1'b1;
          o_retire = 1'b1;
          o_pcWe   = (cls_q == CL_LINK);
        end
        default: ;
      endcase
    end
  end

  assign cyc_d = (state_q != ST_TRAP) ? cyc_q + 1'b1 : cyc_q;
  assign ins_d = ins_q + CNT_W'(o_retire);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cls_q   <= CL_ALU;
      wait_q  <= '0;
      code_q  <= TRAP_NONE;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      code_q  <= code_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  assign o_state    = state_q;
  assign o_trap     = (state_q == ST_TRAP);
  assign o_trapCode = code_q;
  assign o_cycleCnt = cyc_q;
  assign o_instrCnt = ins_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (MEM_TIMEOUT=15, CNT_W=4 so wrap is reachable).
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] i_opcode, i_funct;
  logic [4:0] i_rt;
  logic       i_imem_ready, i_dmem_ready, i_br_taken;
  logic [2:0] o_state;
  logic       o_imemReq, o_irWe, o_pcInc, o_pcWe, o_dmemReq, o_dmemWe, o_regWe, o_retire, o_trap;
  logic [1:0] o_trapCode;
  logic [3:0] o_cycleCnt, o_instrCnt;

  int passed = 0;
  int total  = 0;

  mc_ctrl_fsm #(.MEM_TIMEOUT(15), .TO_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_opcode(i_opcode), .i_funct(i_funct), .i_rt(i_rt),
    .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready), .i_br_taken(i_br_taken),
    .o_state(o_state), .o_imemReq(o_imemReq), .o_irWe(o_irWe), .o_pcInc(o_pcInc),
    .o_pcWe(o_pcWe), .o_dmemReq(o_dmemReq), .o_dmemWe(o_dmemWe), .o_regWe(o_regWe),
    .o_retire(o_retire), .o_trap(o_trap), .o_trapCode(o_trapCode),
    .o_cycleCnt(o_cycleCnt), .o_instrCnt(o_instrCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
    i_opcode = op;
    i_funct  = fn;
    i_rt     = rt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_imem_ready = 1'b1; i_dmem_ready = 1'b1; i_br_taken = 1'b1;
    set_instr(6'b000000, 6'b100001, 5'd0);
    tick();
    total++; if (o_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", o_state); else passed++;
    total++; if ({o_imemReq, o_irWe, o_pcInc, o_pcWe, o_regWe, o_retire} !== 6'b0)
      $display("FAIL reset_strobes got %b exp 000000", {o_imemReq, o_irWe, o_pcInc, o_pcWe, o_regWe, o_retire});
    else passed++;
    total++; if ({o_cycleCnt, o_instrCnt, o_trap, o_trapCode} !== 11'd0)
      $display("FAIL reset_counters got cyc=%0d ins=%0d trap=%b code=%0d exp all 0", o_cycleCnt, o_instrCnt, o_trap, o_trapCode);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (o_imemReq !== 1'b1) $display("FAIL reset_first_imemReq got %b exp 1", o_imemReq); else passed++;
  endtask

  task automatic test_alu();
    logic [2:0] exp_st [4];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
    do_reset();
    set_instr(6'b000000, 6'b100001, 5'd3);
    i_imem_ready = 1'b1; i_dmem_ready = 1'b1; i_br_taken = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (o_state !== exp_st[c]) $display("FAIL alu_state c=%0d got %0d exp %0d", c, o_state, exp_st[c]); else passed++;
      total++; if (o_regWe !== (c == 3)) $display("FAIL alu_regWe c=%0d got %b exp %b", c, o_regWe, c == 3); else passed++;
      total++; if (o_retire !== (c == 3)) $display("FAIL alu_retire c=%0d got %b exp %b", c, o_retire, c == 3); else passed++;
      tick();
    end
    total++; if (o_instrCnt !== 4'd1) $display("FAIL alu_instrCnt got %0d exp 1", o_instrCnt); else passed++;
    total++; if (o_cycleCnt !== 4'd4) $display("FAIL alu_cycleCnt got %0d exp 4", o_cycleCnt); else passed++;
    total++; if (o_state !== 3'd0) $display("FAIL alu_back_to_fetch got %0d exp 0", o_state); else passed++;
  endtask

  task automatic test_load();
    logic [2:0] exp_st [8];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    do_reset();
    set_instr(6'b100011, 6'b000000, 5'd4);
    i_imem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      i_dmem_ready = (c == 6);
      #1;
      total++; if (o_state !== exp_st[c]) $display("FAIL lw_state c=%0d got %0d exp %0d", c, o_state, exp_st[c]); else passed++;
      total++; if (o_dmemWe !== 1'b0) $display("FAIL lw_dmemWe c=%0d got %b exp 0", c, o_dmemWe); else passed++;
      total++; if (o_regWe !== (c == 7)) $display("FAIL lw_regWe c=%0d got %b exp %b", c, o_regWe, c == 7); else passed++;
      total++; if (o_dmemReq !== (c >= 3 && c <= 6)) $display("FAIL lw_dmemReq c=%0d got %b exp %b", c, o_dmemReq, c >= 3 && c <= 6); else passed++;
      tick();
    end
    total++; if ({o_state, o_instrCnt, o_cycleCnt} !== {3'd0, 4'd1, 4'd8})
      $display("FAIL lw_done got st=%0d ins=%0d cyc=%0d exp 0/1/8", o_state, o_instrCnt, o_cycleCnt);
    else passed++;
  endtask

  task automatic test_branch();
    do_reset();
    set_instr(6'b000100, 6'b000000, 5'd2);
    i_imem_ready = 1'b1; i_dmem_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      i_br_taken = (t == 1);
      for (int c = 0; c < 3; c++) begin
        #1;
        total++; if (o_state !== 3'(c)) $display("FAIL beq_state t=%0d c=%0d got %0d exp %0d", t, c, o_state, c); else passed++;
        total++; if (o_pcWe !== (c == 2 && t == 1)) $display("FAIL beq_pcWe t=%0d c=%0d got %b exp %b", t, c, o_pcWe, c == 2 && t == 1); else passed++;
        total++; if (o_retire !== (c == 2)) $display("FAIL beq_retire t=%0d c=%0d got %b exp %b", t, c, o_retire, c == 2); else passed++;
        tick();
      end
    end
    total++; if ({o_state, o_instrCnt, o_cycleCnt} !== {3'd0, 4'd2, 4'd6})
      $display("FAIL beq_done got st=%0d ins=%0d cyc=%0d exp 0/2/6", o_state, o_instrCnt, o_cycleCnt);
    else passed++;
  endtask

  task automatic test_illegal();
    bit bad;
    do_reset();
    set_instr(6'b111111, 6'b000000, 5'd0);
    i_imem_ready = 1'b1; i_dmem_ready = 1'b1; i_br_taken = 1'b0;
    tick();
    tick();
    total++; if ({o_state, o_trap, o_trapCode} !== {3'd5, 1'b1, 2'd1})
      $display("FAIL illegal_trap got st=%0d trap=%b code=%0d exp 5/1/1", o_state, o_trap, o_trapCode);
    else passed++;
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (o_trap !== 1'b1 || o_trapCode !== 2'd1 || o_cycleCnt !== 4'd2 || o_instrCnt !== 4'd0 || o_imemReq !== 1'b0)
        bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL illegal_hold got trap=%b cyc=%0d ins=%0d exp 1/2/0 for 100 cycles", o_trap, o_cycleCnt, o_instrCnt); else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if ({o_state, o_trap, o_trapCode, o_cycleCnt, o_instrCnt} !== 14'd0)
      $display("FAIL illegal_reset got st=%0d trap=%b code=%0d cyc=%0d ins=%0d exp all 0", o_state, o_trap, o_trapCode, o_cycleCnt, o_instrCnt);
    else passed++;
    // jalr (R-type funct 001001) is not in the supported set
    set_instr(6'b000000, 6'b001001, 5'd0);
    tick();
    tick();
    total++; if ({o_state, o_trapCode} !== {3'd5, 2'd1}) $display("FAIL jalr_illegal got st=%0d code=%0d exp 5/1", o_state, o_trapCode); else passed++;
  endtask

  task automatic test_imem_timeout();
    do_reset();
    set_instr(6'b000000, 6'b100001, 5'd0);
    i_imem_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #1;
      total++; if ({o_state, o_imemReq} !== {3'd0, 1'b1}) $display("FAIL imem_to_wait c=%0d got st=%0d req=%b exp 0/1", c, o_state, o_imemReq); else passed++;
      tick();
    end
    total++; if ({o_state, o_trap, o_trapCode} !== {3'd5, 1'b1, 2'd2})
      $display("FAIL imem_to_trap got st=%0d trap=%b code=%0d exp 5/1/2", o_state, o_trap, o_trapCode);
    else passed++;
    total++; if (o_cycleCnt !== 4'd15) $display("FAIL imem_to_cycleCnt got %0d exp 15", o_cycleCnt); else passed++;
  endtask

  task automatic test_imem_late();
    do_reset();
    set_instr(6'b000000, 6'b100001, 5'd0);
    for (int c = 0; c < 15; c++) begin
      i_imem_ready = (c == 14);
      #1;
      total++; if (o_irWe !== (c == 14)) $display("FAIL imem_late_irWe c=%0d got %b exp %b", c, o_irWe, c == 14); else passed++;
      tick();
    end
    i_imem_ready = 1'b1;
    total++; if ({o_state, o_trap} !== {3'd1, 1'b0}) $display("FAIL imem_late_decode got st=%0d trap=%b exp 1/0", o_state, o_trap); else passed++;
  endtask

  task automatic test_dmem_timeout();
    do_reset();
    set_instr(6'b100011, 6'b000000, 5'd0);
    i_imem_ready = 1'b1; i_dmem_ready = 1'b0;
    for (int c = 0; c < 18; c++) tick();
    total++; if ({o_state, o_trapCode} !== {3'd5, 2'd3}) $display("FAIL dmem_to_trap got st=%0d code=%0d exp 5/3", o_state, o_trapCode); else passed++;
  endtask

  task automatic test_store();
    do_reset();
    set_instr(6'b101011, 6'b000000, 5'd5);
    i_imem_ready = 1'b1; i_dmem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (o_state !== 3'(c)) $display("FAIL sw_state c=%0d got %0d exp %0d", c, o_state, c); else passed++;
      total++; if ({o_dmemReq, o_dmemWe} !== {(c == 3), (c == 3)}) $display("FAIL sw_dmem c=%0d got %b%b exp %b%b", c, o_dmemReq, o_dmemWe, c == 3, c == 3); else passed++;
      total++; if (o_regWe !== 1'b0) $display("FAIL sw_regWe c=%0d got %b exp 0", c, o_regWe); else passed++;
      tick();
    end
    total++; if ({o_state, o_instrCnt, o_cycleCnt} !== {3'd0, 4'd1, 4'd4})
      $display("FAIL sw_done got st=%0d ins=%0d cyc=%0d exp 0/1/4", o_state, o_instrCnt, o_cycleCnt);
    else passed++;
  endtask

  task automatic test_link_and_mid_reset();
    do_reset();
    set_instr(6'b000011, 6'b000000, 5'd0);
    i_imem_ready = 1'b1; i_dmem_ready = 1'b1; i_br_taken = 1'b0;
    tick(); tick(); tick();
    total++; if ({o_state, o_regWe, o_pcWe, o_retire} !== {3'd4, 3'b111})
      $display("FAIL jal_wb got st=%0d regWe=%b pcWe=%b retire=%b exp 4/1/1/1", o_state, o_regWe, o_pcWe, o_retire);
    else passed++;
    tick();
    set_instr(6'b000001, 6'b000000, 5'b10000);
    tick(); tick(); tick();
    total++; if ({o_state, o_pcWe} !== {3'd4, 1'b1}) $display("FAIL bltzal_wb got st=%0d pcWe=%b exp 4/1", o_state, o_pcWe); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({o_regWe, o_pcWe, o_retire} !== 3'b000)
      $display("FAIL mid_reset_strobes got regWe=%b pcWe=%b retire=%b exp 000", o_regWe, o_pcWe, o_retire);
    else passed++;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if ({o_state, o_instrCnt} !== {3'd0, 4'd0}) $display("FAIL mid_reset_after got st=%0d ins=%0d exp 0/0", o_state, o_instrCnt); else passed++;
  endtask

  task automatic test_back_to_back();
    int pcwe_seen;
    do_reset();
    set_instr(6'b000010, 6'b000000, 5'd0);
    i_imem_ready = 1'b1; i_dmem_ready = 1'b1; i_br_taken = 1'b0;
    pcwe_seen = 0;
    for (int c = 0; c < 51; c++) begin
      #1;
      if (o_pcWe === 1'b1) pcwe_seen++;
      tick();
    end
    total++; if (o_instrCnt !== 4'd1) $display("FAIL jump_wrap_instrCnt got %0d exp 1", o_instrCnt); else passed++;
    total++; if (o_cycleCnt !== 4'd3) $display("FAIL jump_wrap_cycleCnt got %0d exp 3", o_cycleCnt); else passed++;
    total++; if (pcwe_seen !== 17) $display("FAIL jump_pcWe_count got %0d exp 17", pcwe_seen); else passed++;
    total++; if (o_state !== 3'd0) $display("FAIL jump_final_state got %0d exp 0", o_state); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    i_imem_ready = 1'b0; i_dmem_ready = 1'b0; i_br_taken = 1'b0;
    set_instr(6'b000000, 6'b000000, 5'd0);
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_illegal();
    test_imem_timeout();
    test_imem_late();
    test_dmem_timeout();
    test_store();
    test_link_and_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
